// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: opcodes, immediate formats and the
// occupancy states of the skid-buffered immediate generator.
package riscv_pkg;

    typedef logic [2:0] fmt_t;
    typedef logic [1:0] state_t;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Instruction format encodings
    localparam fmt_t FMT_R   = 3'd0;
    localparam fmt_t FMT_I   = 3'd1;
    localparam fmt_t FMT_S   = 3'd2;
    localparam fmt_t FMT_B   = 3'd3;
    localparam fmt_t FMT_U   = 3'd4;
    localparam fmt_t FMT_J   = 3'd5;
    localparam fmt_t FMT_ILL = 3'd7;

    // Buffer occupancy states
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/riscv_imm_decode.sv
// Combinational instruction-format classifier and immediate extractor.
// The immediate is assembled at 32 bits and sign-extended to XLEN.
import riscv_pkg::*;

module riscv_imm_decode #(
    parameter int XLEN = 32
) (
    input  logic [31:0]      inst,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [XLEN-1:0]  imm
);

    logic signed [31:0] imm32;

    // Classify the opcode and gather the scattered immediate bits
    always_comb begin
        fmt     = FMT_ILL;
        illegal = 1'b1;
        imm32   = '0;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OP_LUI, OP_AUIPC: begin
                    fmt     = FMT_U;
                    illegal = 1'b0;
                    imm32   = {inst[31:12], 12'b0};
                end
                OP_JAL: begin
                    fmt     = FMT_J;
                    illegal = 1'b0;
                    imm32   = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
                    fmt     = FMT_I;
                    illegal = 1'b0;
                    imm32   = {{20{inst[31]}}, inst[31:20]};
                end
                OP_STORE: begin
                    fmt     = FMT_S;
                    illegal = 1'b0;
                    imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                OP_BRANCH: begin
                    fmt     = FMT_B;
                    illegal = 1'b0;
                    imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OP_REG: begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Sign-extend from bit 31 (a no-op when XLEN is 32)
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/riscv_imm_gen_pipe.sv
// Registered RISC-V immediate generator with a one-entry skid buffer.
// Stage 0 decodes the incoming instruction and forms pc+imm; stage 1 is the
// main/skid register pair that presents one entry per cycle downstream.
import riscv_pkg::*;

module riscv_imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit EN_TARGET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_target,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc
);

    // Entry layout: {inst, pc, imm, fmt, illegal, target}
    localparam int EW = 32 + XLEN + XLEN + 3 + 1 + XLEN;

    // ---- Stage 0: combinational decode of the presented instruction ----
    logic [2:0]              fmt_p0;
    logic                    ill_p0;
    logic signed [XLEN-1:0]  imm_p0;
    logic signed [XLEN-1:0]  tgt_p0;
    logic [EW-1:0]           ent_p0;

    riscv_imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst    (in_inst),
        .fmt     (fmt_p0),
        .illegal (ill_p0),
        .imm     (imm_p0)
    );

    generate
        if (EN_TARGET) begin : g_target
            // Modulo-2^XLEN add; carry out is deliberately dropped
            assign tgt_p0 = $signed(in_pc) + imm_p0;
        end else begin : g_no_target
            assign tgt_p0 = '0;
        end
    endgenerate

    assign ent_p0 = {in_inst, in_pc, imm_p0, fmt_p0, ill_p0, tgt_p0};

    // ---- Stage 1: main/skid storage and occupancy control ----
    state_t          state_p1;
    logic [EW-1:0]   main_p1;
    logic [EW-1:0]   skid_p1;
    logic            vld_p1;
    logic            in_fire;
    logic            out_fire;
    logic            load_main_new;
    logic            load_main_skid;
    logic            load_skid;

    // in_ready depends only on the state register, never on out_ready
    assign in_ready = (state_p1 != ST_FULL);
    assign vld_p1   = (state_p1 == ST_ONE) || (state_p1 == ST_FULL);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p1 && out_ready;

    // Main takes the new entry when empty or when it drains in the same cycle
    assign load_main_new  = in_fire && ((state_p1 == ST_EMPTY) || out_fire);
    assign load_main_skid = out_fire && (state_p1 == ST_FULL);
    assign load_skid      = in_fire && !out_fire && (state_p1 == ST_ONE);

    // Occupancy state; flush overrides every handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= ST_EMPTY;
        end else if (flush) begin
            state_p1 <= ST_EMPTY;
        end else begin
            case (state_p1)
                ST_EMPTY: if (in_fire) state_p1 <= ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      state_p1 <= ST_FULL;
                    else if (!in_fire && out_fire) state_p1 <= ST_EMPTY;
                end
                ST_FULL:  if (out_fire) state_p1 <= ST_ONE;
                default:  state_p1 <= ST_EMPTY;
            endcase
        end
    end

    // Entry registers; cleared on reset so outputs read zero while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else if (!flush) begin
            if (load_main_new)       main_p1 <= ent_p0;
            else if (load_main_skid) main_p1 <= skid_p1;
            if (load_skid)           skid_p1 <= ent_p0;
        end
    end

    assign out_valid = vld_p1;
    assign {out_inst, out_pc, out_imm, out_fmt, out_illegal, out_target} = main_p1;

endmodule

// File: doc/riscv_imm_gen_pipe.md
Name: riscv_imm_gen_pipe

Overview:
Registered, parametrised successor to the combinational RISC-V immediate generator. Accepts one 32-bit instruction plus PC per handshake. Classifies the instruction format, sign-extends the immediate to XLEN and, optionally, computes PC+imm. Sits between fetch and decode/execute as a one-stage elastic buffer with valid/ready on both sides, plus flush.

Parameters:
XLEN, 32, datapath width of imm, pc and target; legal values 32 or 64.
EN_TARGET, 1, 1 = compute target = pc + imm; 0 = target driven to zero.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous assert, active-high.
flush  in  1  synchronous drop of all buffered entries.
in_valid  in  1  upstream entry valid.
in_ready  out  1  block can accept an entry.
in_inst  in  32  instruction word.
in_pc  in  XLEN  PC of in_inst.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts the entry.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 ILLEGAL.
out_illegal  out  1  opcode not recognised, or inst[1:0] != 2'b11.
out_target  out  XLEN  pc + imm (EN_TARGET=1), else 0.
out_inst  out  32  registered instruction.
out_pc  out  XLEN  registered PC.

Behaviour:
- Reset: state EMPTY. out_valid=0, in_ready=1, all data outputs 0.
- Opcode map on inst[6:0]:
  - 0110111 and 0010111 -> U.
  - 1101111 -> J.
  - 1100111, 0000011, 0010011, 0001111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110011 -> R.
  - anything else -> ILLEGAL.
- Immediate by format:
  - I: {sext inst[31], inst[31:20]}.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, sign-extended beyond bit 31 when XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and ILLEGAL: imm = 0.
- Every immediate is sign-extended from its top bit to XLEN.
- target = pc + imm, modulo 2^XLEN (wraps, no flag).
- Computed combinationally from the input and captured at the handshake, giving a latency of 1 cycle.
- Handshake: an entry transfers when valid && ready on that side. Output data stays stable while out_valid && !out_ready.
- Storage is a main register plus a skid register. States:
  - EMPTY: in_ready=1, out_valid=0. Input fire -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input only -> FULL; the new entry goes to skid.
    - Output only -> EMPTY.
    - Both -> stay ONE; main is loaded with the new entry.
  - FULL: in_ready=0, out_valid=1 (main shown). Output fire -> ONE; skid moves to main.
- in_ready is a registered function of state only; no combinational path from out_ready to in_ready.
- Full throughput: with out_ready held high, one entry per cycle, no bubbles.
- flush: next state EMPTY and out_valid=0 on the following edge. An input presented in the same cycle is discarded. flush overrides all handshakes.
- Async reset mid-operation: immediate return to reset values. No entry survives.
- out_illegal=1 implies out_fmt=7 and imm=0. Illegal entries still flow through the pipe; no stall, no exception here.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM).
  - format encodings FMT_R..FMT_J, FMT_ILL.
  - state encodings.
- Sub-module riscv_imm_decode: purely combinational, XLEN-parametrised. Takes inst, produces fmt, illegal and imm.
- Top level holds the skid FSM and the target adder.

Test Plan:
- I-type, XLEN=32: 0x00A00013 -> imm 0x0000000A, fmt 1. 0x7FF00013 -> 0x000007FF. 0x80200013 -> 0xFFFFF802, one cycle after accept.
- B and J: 0x00000763 with pc 0x100 -> imm 14, fmt 3, target 0x10E. 0x00E0006F -> imm 14, fmt 5. U: 0x800000B7 at XLEN=64 -> imm 0xFFFFFFFF80000000, fmt 4.
- Backpressure: send 3 entries back-to-back with out_ready=0.
  - Accept 2, then in_ready=0.
  - Outputs stay stable.
  - Release out_ready: entries emerge in order, no loss or duplicate.
  - Streaming with out_ready=1: 1 entry/cycle.
- Illegal and wrap: 0x0000007F -> fmt 7, illegal 1, imm 0. pc 0xFFFFFFFC with J imm 8 -> target 0x00000004.
- flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1. Neither buffered entry nor the flushed input ever appears.
- Assert rst asynchronously mid-stream (between edges) -> outputs return to zero immediately. After release, the first new entry is processed normally.
